// File: rtl/bram_log_reader_if.sv
// Output word stream of the BRAM log reader: one 32-bit word per accepted transfer.
interface bram_log_reader_if;
  // A word transfers on a rising clock edge where Valid_S && Ready_S. Once Valid_S
  // is high, Data_D/Last_S/Valid_S are held until accepted. Ready_S may change freely.
  logic        Valid_S;
  logic        Ready_S;
  logic [31:0] Data_D;
  logic        Last_S;

  modport master (output Valid_S, output Data_D, output Last_S, input Ready_S);
  modport slave  (input Valid_S, input Data_D, input Last_S, output Ready_S);
endinterface

// File: rtl/bram_log_reader.sv
// Drains timestamped log entries from a logger BRAM port and streams them as 32-bit words.
// Macro BRAM_LOG_READER_PREFETCH_EN adds a second entry buffer with read-ahead.
module bram_log_reader #(
    parameter  int LOG_DATA_BITW   = 32,
    parameter  int NUM_LOG_ENTRIES = 16384,
    localparam int ENTRY_BITW      = ((32 + LOG_DATA_BITW + 31) / 32) * 32,
    localparam int WORDS           = ENTRY_BITW / 32,
    localparam int CNT_BITW        = $clog2(NUM_LOG_ENTRIES),
    localparam int ADDR_BITW       = CNT_BITW + $clog2(ENTRY_BITW / 8)
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Start_SI,
    input  logic [CNT_BITW:0]     NumEntries_DI,
    input  logic                  Abort_SI,
    output logic                  BramEn_SO,
    output logic [ADDR_BITW-1:0]  BramAddr_SO,
    input  logic [ENTRY_BITW-1:0] BramRd_DI,
    bram_log_reader_if.master     Strm,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic [2:0]            DbgState_SO
);

    localparam int BYTE_SH = $clog2(ENTRY_BITW / 8);
    localparam int W_BITW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_BITW:0]  MAX_N     = (CNT_BITW + 1)'(NUM_LOG_ENTRIES);
    localparam logic [W_BITW-1:0]  LAST_WORD = W_BITW'(WORDS - 1);
`ifdef BRAM_LOG_READER_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, FINISH} state_e;

    state_e                state_q, state_d;
    logic [CNT_BITW:0]     num_q, num_d;
    logic [CNT_BITW:0]     rd_idx_q, rd_idx_d;
    logic [CNT_BITW:0]     out_idx_q, out_idx_d;
    logic [W_BITW-1:0]     word_q, word_d;
    logic                  out_sel_q, out_sel_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_buf_q, rd_buf_d;
    logic [1:0]            vld_q, vld_d;
    logic [ENTRY_BITW-1:0] ent_buf_q [2];
    logic [CNT_BITW:0]     start_n;
    logic                  hs, last_hs, other_ready;

    assign start_n     = (NumEntries_DI > MAX_N) ? MAX_N : NumEntries_DI;
    assign DbgState_SO = state_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        rd_idx_d    = rd_idx_q;
        out_idx_d   = out_idx_q;
        word_d      = word_q;
        out_sel_d   = out_sel_q;
        rd_pend_d   = 1'b0;
        rd_buf_d    = rd_buf_q;
        vld_d       = vld_q;
        BramEn_SO   = 1'b0;
        BramAddr_SO = '0;
        Busy_SO     = (state_q != IDLE) && (state_q != FINISH);
        Done_SO     = (state_q == FINISH);
        Strm.Valid_S = (state_q == STREAM);
        Strm.Data_D  = (state_q == STREAM) ? ent_buf_q[out_sel_q][32*word_q +: 32] : 32'd0;
        Strm.Last_S  = (state_q == STREAM) && (word_q == LAST_WORD)
                       && ((out_idx_q + 1'b1) == num_q);
        hs          = Strm.Valid_S && Strm.Ready_S;
        last_hs     = hs && (word_q == LAST_WORD);
        // The other buffer holds the next entry, or its read data lands this cycle.
        other_ready = vld_q[~out_sel_q] || (rd_pend_q && (rd_buf_q == ~out_sel_q));

        if (rd_pend_q) vld_d[rd_buf_q] = 1'b1;

        case (state_q)
            IDLE: begin
                if (Start_SI) begin
                    num_d     = start_n;
                    rd_idx_d  = '0;
                    out_idx_d = '0;
                    word_d    = '0;
                    out_sel_d = 1'b0;
                    vld_d     = '0;
                    state_d   = (start_n == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                BramEn_SO   = 1'b1;
                BramAddr_SO = {rd_idx_q[CNT_BITW-1:0], {BYTE_SH{1'b0}}};
                rd_idx_d    = rd_idx_q + 1'b1;
                rd_pend_d   = 1'b1;
                rd_buf_d    = out_sel_q;
                state_d     = WAIT;
            end
            WAIT: begin
                word_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (PREFETCH && !last_hs && !rd_pend_q && !vld_q[~out_sel_q]
                    && (rd_idx_q < num_q)) begin
                    BramEn_SO   = 1'b1;
                    BramAddr_SO = {rd_idx_q[CNT_BITW-1:0], {BYTE_SH{1'b0}}};
                    rd_idx_d    = rd_idx_q + 1'b1;
                    rd_pend_d   = 1'b1;
                    rd_buf_d    = ~out_sel_q;
                end
                if (last_hs) begin
                    vld_d[out_sel_q] = 1'b0;
                    word_d           = '0;
                    if ((out_idx_q + 1'b1) == num_q) begin
                        state_d = FINISH;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                        if (PREFETCH && other_ready) out_sel_d = ~out_sel_q;
                        else                         state_d   = FETCH;
                    end
                end else if (hs) begin
                    word_d = word_q + 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over any handshake; pending read data and buffered entries are dropped.
        if (Abort_SI && (state_q != IDLE) && (state_q != FINISH)) begin
            state_d   = FINISH;
            vld_d     = '0;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q      <= IDLE;
            num_q        <= '0;
            rd_idx_q     <= '0;
            out_idx_q    <= '0;
            word_q       <= '0;
            out_sel_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_buf_q     <= 1'b0;
            vld_q        <= '0;
            ent_buf_q[0] <= '0;
            ent_buf_q[1] <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            rd_idx_q  <= rd_idx_d;
            out_idx_q <= out_idx_d;
            word_q    <= word_d;
            out_sel_q <= out_sel_d;
            rd_pend_q <= rd_pend_d;
            rd_buf_q  <= rd_buf_d;
            vld_q     <= vld_d;
            if (rd_pend_q) ent_buf_q[rd_buf_q] <= BramRd_DI;
        end
    end

endmodule
